// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake bundle between MEM stage and load/store unit
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [1:0]        resp_code;
    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_code
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_code
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store controller for a big-endian data memory
module load_store_unit #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic [1:0]        mem_write,
    output logic [1:0]        mem_read,
    input  logic [31:0]       mem_readdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state, state_n;
    logic [3:0]        op, op_n;
    logic [ADDR_W-1:0] address_n;
    logic [31:0]       writedata_n, rdata_n, load_ext;
    logic [1:0]        write_n, read_n, code_n, err_code, req_size;
    logic              valid_n, err_n;
    assign req_size = bus.req_op[1:0];
    // classify the offered request: illegal beats misaligned beats out of range
    always_comb begin
        err_code = req_size == 2'd0 ? 2'd3 :
                   ((req_size == 2'd2 && bus.req_addr[0]) ||
                    (req_size == 2'd3 && bus.req_addr[1:0] != 2'd0)) ? 2'd1 :
                   bus.req_addr >= ADDR_W'(MEM_BYTES) ? 2'd2 : 2'd0;
    end
    // extend the sampled read data according to the captured op; stores return zero
    always_comb begin
        load_ext = op[3] ? 32'd0 :
                   op[1:0] == 2'd1 ? (op[2] ? {24'd0, mem_readdata[7:0]}
                                            : {{24{mem_readdata[7]}}, mem_readdata[7:0]}) :
                   op[1:0] == 2'd2 ? (op[2] ? {16'd0, mem_readdata[15:0]}
                                            : {{16{mem_readdata[15]}}, mem_readdata[15:0]}) :
                   mem_readdata;
    end
    // next-state and next-output logic; every output is then registered
    always_comb begin
        state_n     = state;
        op_n        = op;
        address_n   = mem_address;
        writedata_n = mem_writedata;
        write_n     = 2'd0;
        read_n      = 2'd0;
        valid_n     = bus.resp_valid;
        err_n       = bus.resp_err;
        code_n      = bus.resp_code;
        rdata_n     = bus.resp_rdata;
        case (state)
            IDLE: if (bus.req_valid) begin
                op_n = bus.req_op;
                if (err_code != 2'd0) begin
                    state_n = RESP;
                    valid_n = 1'b1;
                    err_n   = 1'b1;
                    code_n  = err_code;
                    rdata_n = 32'd0;
                end else begin
                    state_n     = ACCESS;
                    address_n   = bus.req_addr;
                    writedata_n = bus.req_wdata;
                    write_n     = bus.req_op[3] ? req_size : 2'd0;
                    read_n      = bus.req_op[3] ? 2'd0 : req_size;
                end
            end
            ACCESS: begin
                state_n = RESP;
                valid_n = 1'b1;
                err_n   = 1'b0;
                code_n  = 2'd0;
                rdata_n = load_ext;
            end
            RESP: if (bus.resp_ready) begin
                state_n = IDLE;
                valid_n = 1'b0;
                err_n   = 1'b0;
                code_n  = 2'd0;
                rdata_n = 32'd0;
            end
            default: state_n = IDLE;
        endcase
    end
    // state and output registers; reset drops the strobes immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op             <= 4'd0;
            mem_address    <= '0;
            mem_writedata  <= 32'd0;
            mem_write      <= 2'd0;
            mem_read       <= 2'd0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_code  <= 2'd0;
            bus.resp_rdata <= 32'd0;
        end else begin
            state          <= state_n;
            op             <= op_n;
            mem_address    <= address_n;
            mem_writedata  <= writedata_n;
            mem_write      <= write_n;
            mem_read       <= read_n;
            bus.req_ready  <= state_n == IDLE;
            bus.resp_valid <= valid_n;
            bus.resp_err   <= err_n;
            bus.resp_code  <= code_n;
            bus.resp_rdata <= rdata_n;
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequential load/store controller between the MEM-stage pipeline logic and the byte-addressed, big-endian data memory. It accepts one load/store request over a valid/ready handshake and checks alignment, range and opcode. It drives the memory's 2-bit size strobes for exactly one registered cycle, then returns sign- or zero-extended load data, or an error, over a valid/ready response handshake.

Parameters:
MEM_BYTES, 256, data memory size in bytes; must be a multiple of 4
ADDR_W, 32, request/memory address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  4  bit3 = store; bit2 = unsigned load; bits1:0 = size (1 byte, 2 half, 3 word, 0 illegal)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  request rejected, no memory access made
resp_code  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal op
mem_address  out  ADDR_W  to data memory Address
mem_writedata  out  32  to data memory WriteData, right-justified
mem_write  out  2  size strobe to MemWrite; nonzero only in ACCESS
mem_read  out  2  size strobe to MemRead; nonzero only in ACCESS
mem_readdata  in  32  from data memory ReadData (combinational, right-justified, upper bits zero)

Behaviour:
- Reset, asynchronous and immediate: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_code=00, resp_rdata=0; mem_write=0, mem_read=0, mem_address=0, mem_writedata=0.
- All outputs are registered. The memory acts on level, so strobes must be glitch-free and zero outside ACCESS.
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid the op, addr and wdata are captured and classified:
  - Classification priority: illegal (size 0) > misaligned (half with addr[0]=1; word with addr[1:0]!=0) > out of range (addr >= MEM_BYTES).
  - Error: go to RESP with resp_err=1, resp_code set, resp_rdata=0. No strobe is ever asserted.
  - OK: go to ACCESS. mem_address and mem_writedata are loaded, and mem_write or mem_read is set to the size code in the same edge.
- ACCESS: lasts exactly one cycle. Address, data and strobe are stable for the whole cycle.
  - Load: mem_readdata is sampled at the closing edge.
  - Byte load: signed extends bit 7, unsigned zero-fills. Half load: signed extends bit 15, unsigned zero-fills. Word load: passed through.
  - Store: resp_rdata=0.
  - The unsigned bit is ignored for stores and for word loads.
  - Closing edge: strobes return to 0, resp_valid=1, resp_code=00, go to RESP.
- RESP: resp_valid=1, and all resp_* outputs are held stable until resp_ready=1. On resp_ready: resp_valid=0, go to IDLE. resp_ready is ignored outside RESP.
- req_ready=0 in ACCESS and in RESP. Requests offered there are not captured.
- Latency, with acceptance at edge T:
  - Good request: ACCESS cycle after edge T; resp_valid visible after edge T+1. With resp_ready held high, req_ready is back after edge T+2, so throughput is 1 request per 3 cycles.
  - Error: resp_valid visible after edge T.
- In range, aligned accesses never cross MEM_BYTES, because MEM_BYTES is a multiple of 4.
- Reset asserted during ACCESS: strobes drop asynchronously. A partially applied store is not rolled back, and the transaction is discarded with no response.
- Reset during RESP discards the pending response.

Test Plan:
- Reset with req_valid=1 held → all outputs at reset values, no strobe. After rst_n rises, a request is captured on the first edge.
- SW addr 0x10, wdata 0xDEADBEEF → mem_write=3 for exactly 1 cycle with mem_address=0x10. Then LW 0x10 → resp_rdata=0xDEADBEEF, resp_code=00, resp_valid after 2 edges.
- Memory byte 0x20 = 0x80 → LB gives 0xFFFFFF80 and LBU gives 0x00000080. Halfword 0x22–0x23 = 0x8001 → LH gives 0xFFFF8001 and LHU gives 0x00008001; mem_read=2.
- LW addr 0x13 → resp_err=1, code 01. LH addr 0x100 → code 10. Op size 0 at addr 0x101 → code 11. Store-word-class op at 0x13 → code 01. For every error case, mem_write=mem_read=0 throughout and memory is unchanged.
- resp_ready held low 5 cycles after LW → resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored. Then resp_ready=1 for 1 cycle → IDLE, next request accepted.
- rst_n pulsed low in mid-ACCESS of an SB → strobes drop asynchronously and state returns to IDLE. No resp_valid is ever asserted for that SB.
